simple_memory: RTL and testbench

- Word-organised data RAM used as the data memory of the RISC-V pipeline's memory stage.
- Reads are combinational, so the memory stage can register the load result on the same edge on which the address is presented.
- Writes are synchronous, one full 32-bit word per clock.
- Synchronous reset clears the whole array to zero.

---
 rtl/simple_memory.sv | 49 ++++
 tb/tb_simple_memory.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/simple_memory.sv
// rtl/simple_memory.sv - word-organised data RAM, combinational read, synchronous write
module simple_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] r_valid;

    logic [IDX_W-1:0] w_index;
    logic             w_in_range;

    assign w_index    = address[IDX_W+1:2];
    assign w_in_range = (address[ADDR_WIDTH-1:IDX_W+2] == '0);

    // Reset clears one valid bit per word instead of the storage itself;
    // an invalid word reads as zero, which is indistinguishable from a cleared array.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (write_enable && w_in_range) begin
            r_valid[w_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && write_enable && w_in_range) begin
            r_mem[w_index] <= write_data;
        end
    end

    always_comb begin
        read_data = '0;
        if (w_in_range && r_valid[w_index]) begin
            read_data = r_mem[w_index];
        end
    end

endmodule

// File: tb/tb_simple_memory.sv
// tb/tb_simple_memory.sv - directed and randomized checks of simple_memory against a word-array model
module tb_simple_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] read_data;
    logic [31:0] write_data;
    logic        write_enable;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] model [1024];

    simple_memory #(
        .DEPTH_WORDS(1024),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .read_data   (read_data),
        .write_data  (write_data),
        .write_enable(write_enable)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr < 32'd4096) return model[addr / 4];
        return 32'h0;
    endfunction

    task automatic model_edge(input logic r, input logic we, input logic [31:0] addr,
                              input logic [31:0] data);
        if (r) begin
            for (int i = 0; i < 1024; i++) model[i] = 32'h0;
        end else if (we && addr < 32'd4096) begin
            model[addr / 4] = data;
        end
    endtask

    task automatic check_now(input string tag, input logic [31:0] expected);
        vectors++;
        assert (read_data === expected)
        else begin
            errors++;
            $error("FAIL %s addr=%h observed=%h expected=%h", tag, address, read_data, expected);
        end
    endtask

    task automatic check_addr(input string tag, input logic [31:0] addr);
        address = addr;
        #1;
        check_now(tag, model_read(addr));
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge(rst, write_enable, address, write_data);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        address      = addr;
        write_data   = data;
        write_enable = 1'b1;
        clock_edge();
        write_enable = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        r;

        rst          = 1'b1;
        address      = 32'h0;
        write_data   = 32'h0;
        write_enable = 1'b0;
        clock_edge();
        clock_edge();
        rst = 1'b0;

        check_addr("reset_0x0", 32'h0);
        check_addr("reset_0x4", 32'h4);
        check_addr("reset_0xffc", 32'hFFC);
        check_now("reset_0xffc_const", 32'h0);

        do_write(32'h10, 32'hDEADBEEF);
        check_addr("write_0x10", 32'h10);
        check_now("write_0x10_const", 32'hDEADBEEF);
        check_addr("neighbour_0x14", 32'h14);

        do_write(32'h20, 32'h11111111);
        do_write(32'h24, 32'h22222222);
        address = 32'h20;
        #1;
        check_now("comb_0x20", 32'h11111111);
        address = 32'h24;
        #1;
        check_now("comb_0x24", 32'h22222222);

        do_write(32'h33, 32'hA5A5A5A5);
        check_addr("misaligned_0x30", 32'h30);
        check_now("misaligned_0x30_const", 32'hA5A5A5A5);
        check_addr("misaligned_0x31", 32'h31);

        address      = 32'h30;
        write_data   = 32'h5A5A5A5A;
        write_enable = 1'b1;
        #1;
        check_now("rdw_before", 32'hA5A5A5A5);
        clock_edge();
        check_now("rdw_after", 32'h5A5A5A5A);
        write_data = 32'h0F0F0F0F;
        clock_edge();
        write_enable = 1'b0;
        check_now("hold_last_wins", 32'h0F0F0F0F);

        do_write(32'h1000, 32'h12345678);
        check_addr("oor_0x1000", 32'h1000);
        check_now("oor_0x1000_const", 32'h0);
        check_addr("oor_nowrap_0x0", 32'h0);
        check_now("oor_nowrap_0x0_const", 32'h0);
        check_addr("oor_top", 32'hFFFF_FFFC);

        rst          = 1'b1;
        address      = 32'h8;
        write_data   = 32'hFFFFFFFF;
        write_enable = 1'b1;
        clock_edge();
        rst          = 1'b0;
        write_enable = 1'b0;
        check_addr("rst_prio_0x8", 32'h8);
        check_now("rst_prio_0x8_const", 32'h0);
        check_addr("rst_clears_0x10", 32'h10);
        check_now("rst_clears_0x10_const", 32'h0);

        // Random traffic concentrated on a small window so reads hit earlier writes.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = $urandom_range(0, 4095);
                default: a = $urandom_range(0, 63);
            endcase
            d  = $urandom;
            we = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 49) == 0);
            address      = a;
            write_data   = d;
            write_enable = we;
            rst          = r;
            #1;
            check_now("rand_pre_edge", model_read(a));
            clock_edge();
            check_now("rand_post_edge", model_read(a));
            rst          = 1'b0;
            write_enable = 1'b0;
            check_addr("rand_probe", 32'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
